// File: rtl/cic_row_param.sv
// cic_row_param: a row of NUM_CHANNELS independent CIC decimators.
// Each channel takes one modulator bit per clock into an ORDER-stage
// integrator chain. Every R = 2^dec_log2 clocks the last integrator feeds
// an ORDER-stage comb chain with differential delay 1. After warm-up, each
// decimated frame is parked in a holding buffer and streamed out one
// channel per handshake.
// Optional build macro: CIC_DIGITAL_MONITOR_EN adds a registered tap on any
// integrator/comb stage of any channel (mon_out). Without it mon_out is tied to 0.
//
// Control FSM
//   state  | meaning
//   IDLE   | filter stopped, datapath held at zero
//   RUN    | integrating; decimation counter and comb chain active
// Readout FSM
//   state  | meaning
//   EMPTY  | holding buffer free, out_valid low
//   STREAM | buffer full, presenting channel out_chan
module cic_row_param #(
  parameter int NUM_CHANNELS = 24,
  parameter int ORDER        = 3,
  parameter int MAX_LOG2_DEC = 8,
  localparam int W  = ORDER * MAX_LOG2_DEC + 1,
  localparam int DW = $clog2(MAX_LOG2_DEC + 1),
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int SW = (2 * ORDER > 1) ? $clog2(2 * ORDER) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DW-1:0]           dec_log2,
  input  logic [NUM_CHANNELS-1:0] in,
  output logic [W-1:0]            out_data,
  output logic [CW-1:0]           out_chan,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  input  logic                    clear_overrun,
  input  logic [CW-1:0]           mon_chan,
  input  logic [SW-1:0]           mon_stage,
  output logic [W-1:0]            mon_out
);

  localparam logic [DW-1:0] DEC_MAX   = DW'(MAX_LOG2_DEC);
  localparam logic [2:0]    WARM_N    = 3'(ORDER);
  localparam logic [CW-1:0] LAST_CHAN = CW'(NUM_CHANNELS - 1);

  typedef enum logic {IDLE, RUN} ctl_state_t;
  typedef enum logic {EMPTY, STREAM} rd_state_t;

  ctl_state_t              ctl_state;
  rd_state_t               rd_state;
  logic [DW-1:0]           dec_clamped;
  logic [DW-1:0]           dec_eff;
  logic [MAX_LOG2_DEC-1:0] dec_cnt;
  logic [MAX_LOG2_DEC-1:0] r_m1;
  logic [2:0]              warm;
  logic                    run_active;
  logic                    run_stop;
  logic                    tick;
  logic                    warm_done;
  logic                    deliver;
  logic                    hs;
  logic                    last_chan;
  logic                    final_hs;
  logic                    load;
  logic                    overrun_set;
  logic [CW-1:0]           next_chan;

  logic [W-1:0] integ     [NUM_CHANNELS][ORDER];
  logic [W-1:0] comb_d0   [NUM_CHANNELS];
  logic [W-1:0] comb      [NUM_CHANNELS][ORDER];
  logic [W-1:0] comb_nxt  [NUM_CHANNELS][ORDER];
  logic [W-1:0] frame_buf [NUM_CHANNELS];

  // Effective decimation: 0 behaves as 1, anything above the maximum clamps.
  always_comb begin
    dec_clamped = dec_log2;
    if (dec_log2 == '0) begin
      dec_clamped = DW'(1);
    end else if (dec_log2 > DEC_MAX) begin
      dec_clamped = DEC_MAX;
    end
  end

  assign r_m1       = ~({MAX_LOG2_DEC{1'b1}} << dec_eff);
  assign run_active = (ctl_state == RUN) && enable;
  assign run_stop   = (ctl_state == RUN) && !enable;
  assign tick       = run_active && (dec_cnt == r_m1);
  assign warm_done  = (warm == WARM_N);
  assign deliver    = tick && warm_done;

  // Control FSM: latches the ratio on entry, runs the decimation counter and warm-up count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_state <= IDLE;
      dec_eff   <= DW'(1);
      dec_cnt   <= '0;
      warm      <= '0;
    end else begin
      case (ctl_state)
        IDLE: begin
          dec_cnt <= '0;
          warm    <= '0;
          if (enable) begin
            ctl_state <= RUN;
            dec_eff   <= dec_clamped;
          end
        end
        RUN: begin
          if (!enable) begin
            ctl_state <= IDLE;
            dec_cnt   <= '0;
            warm      <= '0;
          end else begin
            dec_cnt <= tick ? '0 : dec_cnt + 1'b1;
            if (tick && !warm_done) begin
              warm <= warm + 3'd1;
            end
          end
        end
        default: ctl_state <= IDLE;
      endcase
    end
  end

  // Comb chain evaluated on the current last-integrator value; the delay of
  // stage k>0 is simply the previous output of stage k-1.
  always_comb begin
    logic [W-1:0] acc;
    acc = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      acc = integ[c][ORDER-1] - comb_d0[c];
      comb_nxt[c][0] = acc;
      for (int k = 1; k < ORDER; k++) begin
        acc = acc - comb[c][k-1];
        comb_nxt[c][k] = acc;
      end
    end
  end

  // Integrators every clock in RUN, combs on tick; everything cleared when not running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        comb_d0[c] <= '0;
        for (int k = 0; k < ORDER; k++) begin
          integ[c][k] <= '0;
          comb[c][k]  <= '0;
        end
      end
    end else if (!run_active) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        comb_d0[c] <= '0;
        for (int k = 0; k < ORDER; k++) begin
          integ[c][k] <= '0;
          comb[c][k]  <= '0;
        end
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        integ[c][0] <= integ[c][0] + W'(in[c]);
        for (int k = 1; k < ORDER; k++) begin
          integ[c][k] <= integ[c][k] + integ[c][k-1];
        end
        if (tick) begin
          comb_d0[c] <= integ[c][ORDER-1];
          for (int k = 0; k < ORDER; k++) begin
            comb[c][k] <= comb_nxt[c][k];
          end
        end
      end
    end
  end

  assign hs          = out_valid && out_ready;
  assign last_chan   = (out_chan == LAST_CHAN);
  assign final_hs    = hs && last_chan;
  assign load        = deliver && ((rd_state == EMPTY) || final_hs);
  assign overrun_set = deliver && !load;
  assign next_chan   = out_chan + 1'b1;

  // Holding buffer; its contents only matter while streaming, so it has no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        frame_buf[c] <= comb_nxt[c][ORDER-1];
      end
    end
  end

  // Readout FSM with registered outputs and the sticky overrun flag (set beats clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state  <= EMPTY;
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
      if (run_stop) begin
        rd_state  <= EMPTY;
        out_valid <= 1'b0;
        out_chan  <= '0;
        out_data  <= '0;
      end else if (load) begin
        rd_state  <= STREAM;
        out_valid <= 1'b1;
        out_chan  <= '0;
        out_data  <= comb_nxt[0][ORDER-1];
      end else begin
        case (rd_state)
          EMPTY: out_valid <= 1'b0;
          STREAM: begin
            if (hs) begin
              if (last_chan) begin
                rd_state  <= EMPTY;
                out_valid <= 1'b0;
              end else begin
                out_chan <= next_chan;
                out_data <= frame_buf[next_chan];
              end
            end
          end
          default: rd_state <= EMPTY;
        endcase
      end
    end
  end

`ifdef CIC_DIGITAL_MONITOR_EN
  logic [W-1:0] mon_sel;

  // Stage select: 0..ORDER-1 integrators, ORDER..2*ORDER-1 combs; anything else reads 0.
  always_comb begin
    mon_sel = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int s = 0; s < ORDER; s++) begin
        if (int'(mon_chan) == c && int'(mon_stage) == s) begin
          mon_sel = integ[c][s];
        end
        if (int'(mon_chan) == c && int'(mon_stage) == s + ORDER) begin
          mon_sel = comb[c][s];
        end
      end
    end
  end

  // One-cycle registered monitor tap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mon_out <= '0;
    end else begin
      mon_out <= mon_sel;
    end
  end
`else
  logic unused_mon;

  assign mon_out    = '0;
  assign unused_mon = ^{mon_chan, mon_stage};
`endif

endmodule

// File: tb/tb_cic_row_param.sv
// Directed bench for cic_row_param at default parameters (24 ch, order 3, max log2 dec 8).
module tb_cic_row_param;

`ifdef CIC_DIGITAL_MONITOR_EN
  localparam bit MON_EN = 1'b1;
`else
  localparam bit MON_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  dec_log2;
  logic [23:0] in_bits;
  logic [24:0] out_data;
  logic [4:0]  out_chan;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        clear_overrun;
  logic [4:0]  mon_chan;
  logic [2:0]  mon_stage;
  logic [24:0] mon_out;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;
  int n;

  cic_row_param dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .dec_log2     (dec_log2),
    .in           (in_bits),
    .out_data     (out_data),
    .out_chan     (out_chan),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overrun      (overrun),
    .clear_overrun(clear_overrun),
    .mon_chan     (mon_chan),
    .mon_stage    (mon_stage),
    .mon_out      (mon_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Counts negedges until out_valid is seen; an expired budget is a failure.
  task automatic wait_valid(input int max, output int cnt);
    cnt = 0;
    while (!out_valid && cnt < max) begin
      @(negedge clk);
      cnt++;
    end
    if (!out_valid) check("valid_timeout", 32'(out_valid), 1);
  endtask

  // Expects a full 24-word frame with constant value, out_ready held high.
  task automatic check_frame(input string tag, input logic [31:0] exp);
    for (int i = 0; i < 24; i++) begin
      check({tag, "_valid"}, 32'(out_valid), 1);
      check({tag, "_chan"}, 32'(out_chan), i);
      check({tag, "_data"}, 32'(out_data), exp);
      @(negedge clk);
    end
  endtask

  task automatic start(input logic [3:0] dec, input logic [23:0] bits);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    in_bits  = bits;
    dec_log2 = dec;
    enable   = 1'b1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; dec_log2 = 4'd5; in_bits = '0;
    out_ready = 1'b1; clear_overrun = 1'b0; mon_chan = 5'd0; mon_stage = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_chan", 32'(out_chan), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_mon", 32'(mon_out), 0);
    reset = 1'b0;
    @(negedge clk);

    // R=32, all ones: 3 warm-up ticks, 4th tick at cycle 128 delivers 32^3
    start(4'd5, '1);
    wait_valid(300, lat);
    check("a_latency", lat, 129);
    check_frame("a_f1", 32768);
    wait_valid(100, lat);
    check("a_gap", lat, 8);
    check_frame("a_f2", 32768);
    check("a_overrun", 32'(overrun), 0);

    // all zeros
    start(4'd5, '0);
    wait_valid(300, lat);
    check("b_latency", lat, 129);
    check_frame("b_f1", 0);

    // R=8: stream longer than frame period; final handshake coincides with a tick
    start(4'd3, '1);
    wait_valid(100, lat);
    check("c_latency", lat, 33);
    check("c_overrun_pre", 32'(overrun), 0);
    check_frame("c_f1", 512);
    check("c_overrun", 32'(overrun), 1);
    check_frame("c_f2", 512);
    repeat (5) @(negedge clk);

    // async reset mid-stream, then restart from scratch
    reset = 1'b1;
    #1;
    check("g_valid", 32'(out_valid), 0);
    check("g_chan", 32'(out_chan), 0);
    check("g_data", 32'(out_data), 0);
    check("g_overrun", 32'(overrun), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_valid(100, lat);
    check("g_latency", lat, 33);
    check("g_overrun_post", 32'(overrun), 0);
    check_frame("g_f1", 512);

    // back-pressure: hold at channel 5 for 40 cycles
    start(4'd5, '1);
    wait_valid(300, lat);
    for (int i = 0; i < 5; i++) begin
      check("d_chan_pre", 32'(out_chan), i);
      @(negedge clk);
    end
    out_ready = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (j % 10 == 0) begin
        check("d_hold_chan", 32'(out_chan), 5);
        check("d_hold_data", 32'(out_data), 32768);
        check("d_hold_valid", 32'(out_valid), 1);
      end
    end
    check("d_overrun", 32'(overrun), 1);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    check("d_overrun_clr", 32'(overrun), 0);
    out_ready = 1'b1;
    for (int i = 5; i < 24; i++) begin
      check("d_chan_post", 32'(out_chan), i);
      check("d_data_post", 32'(out_data), 32768);
      @(negedge clk);
    end

    // enable dropped mid-stream; overrun retained; re-enable with dec_log2=0
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    check("e_overrun_clr", 32'(overrun), 0);
    start(4'd5, '1);
    wait_valid(300, lat);
    out_ready = 1'b0;
    repeat (35) @(negedge clk);
    check("e_overrun", 32'(overrun), 1);
    out_ready = 1'b1;
    n = 0;
    while (out_chan != 5'd10 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("e_chan10", 32'(out_chan), 10);
    enable = 1'b0;
    @(negedge clk);
    check("e_valid_drop", 32'(out_valid), 0);
    check("e_overrun_kept", 32'(overrun), 1);
    @(negedge clk);
    check("e_valid_idle", 32'(out_valid), 0);
    dec_log2 = 4'd0;
    enable   = 1'b1;
    @(negedge clk);
    dec_log2 = 4'd5;
    wait_valid(50, lat);
    check("e_latency_r2", lat, 8);
    check_frame("e_f1", 8);

    // dec_log2 above maximum clamps to 8: R=256, gain 2^24
    start(4'd15, '1);
    wait_valid(1100, lat);
    check("k_latency", lat, 1025);
    check_frame("k_f1", 16777216);

    // monitor tap on integrator 1 of channel 5
    mon_chan  = 5'd5;
    mon_stage = 3'd0;
    start(4'd5, 24'h000020);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      check("f_mon_integ", 32'(mon_out), MON_EN ? ((j >= 2) ? j - 2 : 0) : 0);
    end
    mon_chan = 5'd30;
    repeat (2) @(negedge clk);
    check("f_mon_badchan", 32'(mon_out), 0);
    mon_chan  = 5'd5;
    mon_stage = 3'd6;
    repeat (2) @(negedge clk);
    check("f_mon_badstage", 32'(mon_out), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cic_row_param.md
CIC_ROW_PARAM -- requirements
Module: cic_row_param

Interface
REQ-001 Parameter NUM_CHANNELS, default 24: number of independent CIC channels, range 1..64.
REQ-002 Parameter ORDER, default 3: CIC order (integrator and comb stages per channel), range 1..4.
REQ-003 Parameter MAX_LOG2_DEC, default 8: maximum log2 of the decimation ratio, range 1..15.
REQ-004 Parameter W is derived as ORDER*MAX_LOG2_DEC+1, default 25: datapath and output word width.
REQ-005 clk  input  1  common high-speed modulator clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  filter run enable.
REQ-008 dec_log2  input  clog2(MAX_LOG2_DEC+1)  log2 of decimation ratio R.
REQ-009 in  input  NUM_CHANNELS  one modulator bit per channel, weighted 0 or 1.
REQ-010 out_data  output  W  decimated word of channel out_chan.
REQ-011 out_chan  output  clog2(NUM_CHANNELS) (min 1)  channel index of out_data.
REQ-012 out_valid  output  1  out_data/out_chan valid.
REQ-013 out_ready  input  1  consumer accepts word when out_valid && out_ready.
REQ-014 overrun  output  1  sticky flag: a decimated frame was dropped.
REQ-015 clear_overrun  input  1  synchronous clear of overrun.
REQ-016 mon_chan  input  clog2(NUM_CHANNELS)  digital-monitor channel select.
REQ-017 mon_stage  input  clog2(2*ORDER)  monitor stage select: 0..ORDER-1 integrators, ORDER..2*ORDER-1 combs.
REQ-018 mon_out  output  W  digital-monitor value.

Function
REQ-019 Control FSM SHALL have states IDLE and RUN; IDLE->RUN when enable=1; RUN->IDLE when enable=0.
REQ-020 On IDLE->RUN, dec_log2 SHALL be latched as effective value; 0 is treated as 1, values > MAX_LOG2_DEC clamp to MAX_LOG2_DEC; changes during RUN are ignored.
REQ-021 In RUN, each channel SHALL add its in bit into integrator 1 every clk, each integrator feeding the next, all W-bit modulo 2^W (two's-complement wrap, no saturation).
REQ-022 Decimation counter SHALL count 0..R-1 in RUN; tick is the cycle where count==R-1; counter then wraps to 0.
REQ-023 On tick, comb chain (differential delay 1) SHALL process the last integrator value, W-bit modulo 2^W; the final comb result is the frame word.
REQ-024 The first ORDER ticks after entering RUN SHALL update combs but not deliver frames (warm-up).
REQ-025 On a delivering tick with holding buffer empty, all NUM_CHANNELS words SHALL load into the buffer; out_valid rises next cycle with out_chan=0.
REQ-026 Readout FSM states EMPTY and STREAM; in STREAM out_data/out_chan SHALL hold until handshake, then advance by one channel; handshake on channel NUM_CHANNELS-1 returns to EMPTY.
REQ-027 Delivering tick while STREAM and not on the final handshake: new frame SHALL be dropped, buffer untouched, overrun set.
REQ-028 Delivering tick coincident with final handshake: no overrun; new frame loads; out_valid stays 1 with out_chan=0 next cycle.
REQ-029 overrun set and clear_overrun in the same cycle: set wins.
REQ-030 On RUN->IDLE, integrators, combs, counter and warm-up count SHALL clear, out_valid SHALL drop next cycle and readout returns to EMPTY; overrun is retained.
REQ-031 Steady-state gain for constant input 1 SHALL be R^ORDER (2^(ORDER*dec_log2)).

Reset
REQ-032 Reset SHALL force IDLE, EMPTY, all integrators/combs/delays/counter to 0, out_data=0, out_chan=0, out_valid=0, overrun=0, mon_out=0.
REQ-033 Reset asserted mid-frame or mid-stream SHALL abort immediately; no partial frame is delivered after release.

Configuration
REQ-034 With macro CIC_DIGITAL_MONITOR_EN defined, mon_out SHALL be a registered copy (1-cycle latency) of stage mon_stage of channel mon_chan; out-of-range selects give 0.
REQ-035 Without CIC_DIGITAL_MONITOR_EN, mon_out SHALL be constant 0 and no monitor mux or register is built; mon_chan/mon_stage are ignored.

Verification
REQ-036 N=24, ORDER=3, dec_log2=5, in all 1s, out_ready=1 -> delivered frames after the 4th all read 32768 on channels 0..23, overrun=0.
REQ-037 Same, in all 0s -> every delivered word 0.
REQ-038 dec_log2=3 (R=8), out_ready=1 -> 24-word stream exceeds 8-cycle frame, overrun=1, delivered frames still complete and in order 0..23.
REQ-039 dec_log2=5, out_ready held 0 for 40 cycles mid-stream -> out_data/out_chan frozen, overrun=1, clear_overrun then clears it.
REQ-040 enable dropped during channel 10 of a stream -> out_valid=0 next cycle; re-enable with dec_log2=0 -> R=2, first ORDER ticks deliver nothing.
REQ-041 Monitor enabled, mon_chan=5, mon_stage=0, in[5]=1 -> mon_out increments by 1 each cycle, one cycle behind integrator 1.
